// File: rtl/commutator_pkg.sv
// Shared types and helpers for the four-step commutation controller.
// The FAULT state exists only when COMMUTATOR_INTERLOCK_EN is defined.
package commutator_pkg;

  localparam int   MAX_PHASES = 32;
  localparam logic SIGN_POS   = 1'b1;
  localparam logic SIGN_NEG   = 1'b0;

  typedef enum logic [3:0] {
    OFF,
    TURN_ON,
    CONDUCT,
    STEP1,
    STEP2,
    STEP3,
    STEP4,
    TURN_OFF
`ifdef COMMUTATOR_INTERLOCK_EN
    ,
    FAULT
`endif
  } state_t;

  // One-hot select of input phase idx; out-of-range indices give all zeros.
  function automatic logic [MAX_PHASES-1:0] phase_onehot(input int unsigned idx,
                                                          input int unsigned n);
    logic [MAX_PHASES-1:0] oh;
    oh = '0;
    if (idx < n && idx < MAX_PHASES) oh = MAX_PHASES'(1) << idx;
    return oh;
  endfunction

endpackage

// File: rtl/four_step_commutator_if.sv
// Phase-request channel from the modulator into one commutator instance.
// Handshake: a request transfers on a clk edge where req_valid & req_ready;
// the master holds req_phase/req_off stable while req_valid is high.
interface four_step_commutator_if #(
  parameter int PH_W = 2
);
  logic            req_valid;
  logic [PH_W-1:0] req_phase;
  logic            req_off;
  logic            req_ready;

  modport master (output req_valid, output req_phase, output req_off, input req_ready);
  modport slave  (input req_valid, input req_phase, input req_off, output req_ready);
endinterface

// File: rtl/commutation_timer.sv
// Loadable down-counter that times one commutation step.
// done is high only on the last cycle of a hold of `value` cycles.
module commutation_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= value - CNT_W'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/four_step_commutator.sv
// Current-sign-based four-step commutation controller for one matrix-converter output leg.
// Optional gate-short interlock and FAULT state: define COMMUTATOR_INTERLOCK_EN.
module four_step_commutator
  import commutator_pkg::*;
#(
  parameter int N_PHASES = 3,
  parameter int PH_W     = $clog2(N_PHASES),
  parameter int CNT_W    = 8,
  parameter int T_OFF    = 9,
  parameter int T_ON     = 1
) (
  input  logic                clk,
  input  logic                rst,
  four_step_commutator_if.slave req,
  input  logic                cur_sign,
  output logic [N_PHASES-1:0] sw_p,
  output logic [N_PHASES-1:0] sw_n,
  output logic [PH_W-1:0]     active_phase,
  output logic                conducting,
  output logic                busy,
  output logic                fault,
  output state_t              dbg_state
);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   active_q, active_d;
  logic [PH_W-1:0]   target_q, target_d;
  logic              sign_q, sign_d;
  logic              armed_q;
  logic              accept, phase_ok, bad_req, fault_set;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_value;
  logic [N_PHASES-1:0] oh_a, oh_t, carry, other;
  logic [N_PHASES-1:0] raw_p, raw_n, gate_p, gate_n;

  // armed_q blocks acceptance on the first edge after reset release.
  assign req.req_ready = armed_q && (state_q == OFF || state_q == CONDUCT);
  assign accept        = req.req_valid && req.req_ready;
  assign phase_ok      = 32'(req.req_phase) < 32'(N_PHASES);
  assign dbg_state     = state_q;

  commutation_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // "carry" is the device set in the current direction, "other" the opposite one.
  always_comb begin
    oh_a  = N_PHASES'(phase_onehot(32'(active_q), N_PHASES));
    oh_t  = N_PHASES'(phase_onehot(32'(target_q), N_PHASES));
    carry = '0;
    other = '0;
    case (state_q)
      TURN_ON, CONDUCT: begin carry = oh_a; other = oh_a; end
      STEP1:            carry = oh_a;
      STEP2:            carry = oh_a | oh_t;
      STEP3:            carry = oh_t;
      STEP4:            begin carry = oh_t; other = oh_t; end
      default:          ;
    endcase
    raw_p = (sign_q == SIGN_POS) ? carry : other;
    raw_n = (sign_q == SIGN_NEG) ? carry : other;
  end

`ifdef COMMUTATOR_INTERLOCK_EN
  logic short_det;

  // Any forward gate on one phase together with a reverse gate on another shorts two inputs.
  always_comb begin
    short_det = 1'b0;
    for (int a = 0; a < N_PHASES; a++) begin
      for (int b = 0; b < N_PHASES; b++) begin
        if (a != b && raw_p[a] && raw_n[b]) short_det = 1'b1;
      end
    end
  end

  assign gate_p    = short_det ? '0 : raw_p;
  assign gate_n    = short_det ? '0 : raw_n;
  assign fault_set = bad_req | short_det;
`else
  assign gate_p    = raw_p;
  assign gate_n    = raw_n;
  assign fault_set = bad_req;
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    target_d  = target_q;
    sign_d    = sign_q;
    tmr_load  = 1'b0;
    tmr_value = CNT_W'(T_ON);
    bad_req   = 1'b0;
    case (state_q)
      OFF: begin
        if (accept && !req.req_off) begin
          if (!phase_ok) begin
            bad_req = 1'b1;
          end else begin
            active_d = req.req_phase;
            state_d  = TURN_ON;
            tmr_load = 1'b1;
          end
        end
      end
      TURN_ON: if (tmr_done) state_d = CONDUCT;
      CONDUCT: begin
        if (accept) begin
          if (req.req_off) begin
            state_d   = TURN_OFF;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(T_OFF);
          end else if (!phase_ok) begin
            bad_req = 1'b1;
          end else if (req.req_phase != active_q) begin
            target_d  = req.req_phase;
            sign_d    = cur_sign;
            state_d   = STEP1;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(T_OFF);
          end
        end
      end
      STEP1: if (tmr_done) begin state_d = STEP2; tmr_load = 1'b1; end
      STEP2: begin
        if (tmr_done) begin
          state_d   = STEP3;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(T_OFF);
        end
      end
      STEP3: if (tmr_done) begin state_d = STEP4; tmr_load = 1'b1; end
      STEP4: begin
        if (tmr_done) begin
          state_d  = CONDUCT;
          active_d = target_q;
        end
      end
      TURN_OFF: if (tmr_done) state_d = OFF;
`ifdef COMMUTATOR_INTERLOCK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = OFF;
    endcase
`ifdef COMMUTATOR_INTERLOCK_EN
    if (short_det) begin
      state_d  = FAULT;
      tmr_load = 1'b0;
    end
`endif
  end

  // Outputs are registered from the state held during the cycle, one edge behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= OFF;
      active_q     <= '0;
      target_q     <= '0;
      sign_q       <= SIGN_POS;
      armed_q      <= 1'b0;
      sw_p         <= '0;
      sw_n         <= '0;
      active_phase <= '0;
      conducting   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      state_q      <= state_d;
      active_q     <= active_d;
      target_q     <= target_d;
      sign_q       <= sign_d;
      sw_p         <= gate_p;
      sw_n         <= gate_n;
      active_phase <= active_q;
      conducting   <= (state_q == CONDUCT);
      busy         <= (state_q == TURN_ON) || (state_q == STEP1) || (state_q == STEP2) ||
                      (state_q == STEP3) || (state_q == STEP4) || (state_q == TURN_OFF);
      fault        <= fault | fault_set;
    end
  end

endmodule
